axi_mem_slave: RTL and testbench

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/axi_mem_slave_if.sv | 60 ++++++
 rtl/axi_mem_slave.sv | 166 ++++++++++++++++
 tb/tb_axi_mem_slave.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle carrying the subset of channel fields the memory responder uses.
// Master drives requests and W data; Slave drives ready, B and R.
interface AXI_BUS #(
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiDataWidth = 32,
    parameter int unsigned AxiIdWidth   = 5,
    parameter int unsigned AxiUserWidth = 1
);
    logic [AxiIdWidth-1:0]     aw_id;
    logic [AxiAddrWidth-1:0]   aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AxiDataWidth-1:0]   w_data;
    logic [AxiDataWidth/8-1:0] w_strb;
    logic                      w_last;
    logic                      w_valid;
    logic                      w_ready;

    logic [AxiIdWidth-1:0]     b_id;
    logic [1:0]                b_resp;
    logic [AxiUserWidth-1:0]   b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AxiIdWidth-1:0]     ar_id;
    logic [AxiAddrWidth-1:0]   ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AxiIdWidth-1:0]     r_id;
    logic [AxiDataWidth-1:0]   r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AxiUserWidth-1:0]   r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_valid, input w_ready,
        input b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, input ar_ready,
        input r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );

    modport Slave (
        input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, output aw_ready,
        input w_data, w_strb, w_last, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
    );
endinterface

// File: rtl/axi_mem_slave.sv
// Single-outstanding AXI4 memory responder with byte-lane block RAM and registered reads.
// Address bits above the memory size alias; WRAP bursts are refused with SLVERR.
module axi_mem_slave #(
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiDataWidth = 32,
    parameter int unsigned AxiIdWidth   = 5,
    parameter int unsigned AxiUserWidth = 1,
    parameter int unsigned MemBytes     = 4096
) (
    input logic   clk_i,
    input logic   rst_i,
    AXI_BUS.Slave slv_port
);
    localparam int unsigned StrbW = AxiDataWidth / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned MemAw = (AxiAddrWidth < $clog2(MemBytes)) ? AxiAddrWidth : $clog2(MemBytes);
    localparam int unsigned IdxW  = MemAw - OffW;
    localparam int unsigned Depth = 2 ** IdxW;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

    state_e                  state_q;
    logic [AxiIdWidth-1:0]   id_q;
    logic [MemAw-1:0]        addr_q, addr_step, addr_nxt;
    logic [7:0]              len_q, beat_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q, bresp_q;
    logic                    err_q, read_pri_q, bvalid_q, rvalid_q, rlast_q;
    logic                    tie, ar_grant, aw_grant, is_wrap;
    logic                    w_hs, w_final, w_err, wr_en, rd_en;
    logic [IdxW-1:0]         wr_idx, rd_idx;
    logic [AxiDataWidth-1:0] rdata;

    // One grant per idle cycle; read_pri_q decides only when both channels request.
    assign tie      = slv_port.aw_valid && slv_port.ar_valid;
    assign ar_grant = !rst_i && (state_q == IDLE) && slv_port.ar_valid
                      && (read_pri_q || !slv_port.aw_valid);
    assign aw_grant = !rst_i && (state_q == IDLE) && slv_port.aw_valid && !ar_grant;

    assign is_wrap   = (burst_q == BurstWrap);
    assign addr_step = (burst_q == BurstFixed) ? '0 : (MemAw'(1) << size_q);
    assign addr_nxt  = addr_q + addr_step;

    assign w_hs    = (state_q == WDATA) && slv_port.w_valid;
    assign w_final = (beat_q == len_q);
    assign w_err   = err_q || (slv_port.w_last != w_final);
    assign wr_en   = w_hs && !is_wrap;
    assign wr_idx  = addr_q[MemAw-1:OffW];

    // The next read word is fetched on the handshake so it is ready one cycle later.
    assign rd_en  = ar_grant || (rvalid_q && slv_port.r_ready && !rlast_q);
    assign rd_idx = ar_grant ? slv_port.ar_addr[MemAw-1:OffW] : addr_nxt[MemAw-1:OffW];

    for (genvar gi = 0; gi < StrbW; gi++) begin : g_lane
        logic [7:0] ram_q [Depth];
        logic [7:0] rd_q;
        always_ff @(posedge clk_i) begin
            if (wr_en && slv_port.w_strb[gi]) begin
                ram_q[wr_idx] <= slv_port.w_data[8*gi +: 8];
            end
            if (rd_en) begin
                rd_q <= ram_q[rd_idx];
            end
        end
        assign rdata[8*gi +: 8] = rd_q;
    end

    assign slv_port.aw_ready = aw_grant;
    assign slv_port.ar_ready = ar_grant;
    assign slv_port.w_ready  = (state_q == WDATA);
    assign slv_port.b_valid  = bvalid_q;
    assign slv_port.b_id     = id_q;
    assign slv_port.b_resp   = bresp_q;
    assign slv_port.b_user   = {AxiUserWidth{1'b0}};
    assign slv_port.r_valid  = rvalid_q;
    assign slv_port.r_id     = id_q;
    assign slv_port.r_data   = is_wrap ? '0 : rdata;
    assign slv_port.r_resp   = is_wrap ? RespSlvErr : RespOkay;
    assign slv_port.r_last   = rlast_q;
    assign slv_port.r_user   = {AxiUserWidth{1'b0}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            read_pri_q <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= RespOkay;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_grant) begin
                        id_q     <= slv_port.ar_id;
                        addr_q   <= slv_port.ar_addr[MemAw-1:0];
                        len_q    <= slv_port.ar_len;
                        size_q   <= slv_port.ar_size;
                        burst_q  <= slv_port.ar_burst;
                        beat_q   <= '0;
                        err_q    <= 1'b0;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (slv_port.ar_len == 8'd0);
                        state_q  <= RDATA;
                        if (tie) read_pri_q <= 1'b0;
                    end else if (aw_grant) begin
                        id_q    <= slv_port.aw_id;
                        addr_q  <= slv_port.aw_addr[MemAw-1:0];
                        len_q   <= slv_port.aw_len;
                        size_q  <= slv_port.aw_size;
                        burst_q <= slv_port.aw_burst;
                        beat_q  <= '0;
                        err_q   <= 1'b0;
                        state_q <= WDATA;
                        if (tie) read_pri_q <= 1'b1;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        err_q <= w_err;
                        // The burst length, not wlast, decides where the burst ends.
                        if (w_final) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= (w_err || is_wrap) ? RespSlvErr : RespOkay;
                            state_q  <= WRESP;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= addr_nxt;
                        end
                    end
                end
                WRESP: begin
                    if (slv_port.b_ready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RDATA: begin
                    if (slv_port.r_ready) begin
                        if (rlast_q) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            addr_q  <= addr_nxt;
                            rlast_q <= ((beat_q + 8'd1) == len_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: a byte-array memory model predicts every B and R beat,
// and a negedge monitor compares the DUT against those predictions each valid cycle.
module tb_axi_mem_slave;
    localparam int AW = 32, DW = 32, IW = 5, UW = 1, MB = 4096;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    AXI_BUS #(.AxiAddrWidth(AW), .AxiDataWidth(DW), .AxiIdWidth(IW), .AxiUserWidth(UW)) bus ();

    axi_mem_slave #(
        .AxiAddrWidth(AW), .AxiDataWidth(DW), .AxiIdWidth(IW), .AxiUserWidth(UW), .MemBytes(MB)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .slv_port(bus)
    );

    int checks = 0;
    int passed = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endfunction

    typedef struct { logic [4:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
    typedef struct { logic [4:0] id; logic [1:0] resp; } bexp_t;

    logic [7:0]  mem_m [MB];
    rbeat_t      exp_r [$];
    bexp_t       exp_b [$];
    bit          grant_log [$];
    rbeat_t      rb;
    bexp_t       bb;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];
    logic [31:0] rcap [16];
    logic [4:0]  rid_cap;
    logic [1:0]  bresp_cap;

    function automatic int beat_addr(logic [31:0] addr, int i, logic [1:0] burst);
        logic [31:0] a;
        a = addr + 32'(i * ((burst == FIXED) ? 0 : 4));
        return int'(a % MB);
    endfunction

    task automatic axi_write(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int bdelay, input bit early_w);
        bit err = 0;
        bit got;
        int n, a, base;
        bexp_t be;
        for (int i = 0; i <= int'(len); i++) if (wl[i] != (i == int'(len))) err = 1;
        if (burst != WRAP) begin
            for (int i = 0; i <= int'(len); i++) begin
                a = beat_addr(addr, i, burst);
                base = a - (a % 4);
                for (int b = 0; b < 4; b++) if (ws[i][b]) mem_m[base + b] = wd[i][8*b +: 8];
            end
        end
        be.id = id;
        be.resp = (err || burst == WRAP) ? 2'b10 : 2'b00;
        exp_b.push_back(be);

        bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = 3'd2;
        bus.aw_burst = burst; bus.aw_valid = 1'b1;
        got = 0;
        if (early_w) begin
            bus.w_data = wd[0]; bus.w_strb = ws[0]; bus.w_last = wl[0]; bus.w_valid = 1'b1;
            @(negedge clk);
            chk("w_ready_before_aw", bus.w_ready, 0);
            got = bus.aw_ready;
        end
        n = 0;
        while (!got) begin
            @(negedge clk);
            got = bus.aw_ready;
            if (!got && ++n > 200) begin chk("aw_timeout", 1, 0); break; end
        end
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;

        for (int i = 0; i <= int'(len); i++) begin
            bus.w_data = wd[i]; bus.w_strb = ws[i]; bus.w_last = wl[i]; bus.w_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus.w_ready && n < 200) begin @(negedge clk); n++; end
            if (!bus.w_ready) chk("w_timeout", 0, 1);
            @(posedge clk); #1;
        end
        bus.w_valid = 1'b0;

        repeat (bdelay) begin @(posedge clk); #1; end
        bus.b_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.b_valid && n < 200) begin @(negedge clk); n++; end
        if (!bus.b_valid) chk("b_timeout", 0, 1);
        bresp_cap = bus.b_resp;
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit toggle, input int abort_after,
                            input bit expect_immediate);
        bit got;
        int n, a, base, beats;
        rbeat_t e;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, i, burst);
            base = a - (a % 4);
            e.id   = id;
            e.data = (burst == WRAP) ? 32'h0
                   : {mem_m[base + 3], mem_m[base + 2], mem_m[base + 1], mem_m[base]};
            e.resp = (burst == WRAP) ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            exp_r.push_back(e);
        end
        bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = 3'd2;
        bus.ar_burst = burst; bus.ar_valid = 1'b1;
        bus.r_ready = toggle ? 1'b0 : 1'b1;
        got = 0; n = 0;
        while (!got) begin
            @(negedge clk);
            got = bus.ar_ready;
            if (expect_immediate && n == 0) chk("ar_ready_first_edge_after_reset", got, 1);
            if (!got && ++n > 200) begin chk("ar_timeout", 1, 0); break; end
        end
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        @(negedge clk);
        chk("r_first_beat_latency", bus.r_valid, 1);

        beats = 0; n = 0;
        while (beats <= int'(len)) begin
            if (bus.r_valid && bus.r_ready) begin
                if (beats == 0) rid_cap = bus.r_id;
                rcap[beats] = bus.r_data;
                beats++;
            end
            if (abort_after != 0 && beats == abort_after) break;
            if (beats > int'(len)) break;
            @(posedge clk); #1;
            if (toggle) bus.r_ready = ~bus.r_ready;
            @(negedge clk);
            if (++n > 500) begin chk("r_timeout", 1, 0); break; end
        end
        @(posedge clk); #1;
        if (abort_after != 0) begin
            chk("r_valid_before_reset", bus.r_valid, 1);
            #1 rst = 1'b1;
            #1 chk("r_valid_async_reset", bus.r_valid, 0);
            exp_r.delete();
            bus.r_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        end else begin
            bus.r_ready = 1'b0;
        end
    endtask

    // Monitor: every valid R/B cycle must match the head of the predicted queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.aw_valid && bus.ar_valid) chk("ready_exclusive", bus.aw_ready && bus.ar_ready, 0);
            if (bus.ar_valid && bus.ar_ready) grant_log.push_back(1'b1);
            if (bus.aw_valid && bus.aw_ready) grant_log.push_back(1'b0);
            if (bus.r_valid) begin
                if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    rb = exp_r[0];
                    chk("rid", bus.r_id, rb.id);
                    chk("rdata", bus.r_data, rb.data);
                    chk("rresp", bus.r_resp, rb.resp);
                    chk("rlast", bus.r_last, rb.last);
                    chk("ruser", bus.r_user, 0);
                    if (bus.r_ready) void'(exp_r.pop_front());
                end
            end
            if (bus.b_valid) begin
                if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                else begin
                    bb = exp_b[0];
                    chk("bid", bus.b_id, bb.id);
                    chk("bresp", bus.b_resp, bb.resp);
                    chk("buser", bus.b_user, 0);
                    if (bus.b_ready) void'(exp_b.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
        bus.aw_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0;
        bus.b_ready = 1'b0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0;
        bus.ar_burst = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b0;

        #2 bus.aw_valid = 1'b1; bus.ar_valid = 1'b1;
        @(negedge clk);
        chk("rst_aw_ready", bus.aw_ready, 0);
        chk("rst_ar_ready", bus.ar_ready, 0);
        chk("rst_w_ready", bus.w_ready, 0);
        chk("rst_b_valid", bus.b_valid, 0);
        chk("rst_r_valid", bus.r_valid, 0);
        bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // Single-beat write then read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl[0] = 1'b1;
        axi_write(5'h01, 32'h10, 8'd0, INCR, 0, 0);
        chk("single_bresp_okay", bresp_cap, 2'b00);
        axi_read(5'h02, 32'h10, 8'd0, INCR, 0, 0, 0);
        chk("single_rdata", rcap[0], 32'hDEADBEEF);

        // INCR burst with B backpressure, read back with toggling rready
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; wl[i] = (i == 3); end
        axi_write(5'h03, 32'h100, 8'd3, INCR, 2, 0);
        axi_read(5'h04, 32'h100, 8'd3, INCR, 1, 0, 0);
        for (int i = 0; i < 4; i++) chk("incr_beat", rcap[i], 32'(i + 1));

        // Byte strobes, first write offers W before AW
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF; wl[0] = 1'b1;
        axi_write(5'h05, 32'h20, 8'd0, INCR, 0, 1);
        wd[0] = 32'h11223344; ws[0] = 4'h5;
        axi_write(5'h06, 32'h20, 8'd0, INCR, 1, 0);
        axi_read(5'h07, 32'h20, 8'd0, INCR, 0, 0, 0);
        chk("strobe_merge", rcap[0], 32'hAA22CC44);

        // WRAP refused on both channels
        wd[0] = 32'h12345678; ws[0] = 4'hF; wl[0] = 1'b1;
        axi_write(5'h08, 32'h20, 8'd0, WRAP, 0, 0);
        chk("wrap_bresp", bresp_cap, 2'b10);
        axi_read(5'h09, 32'h20, 8'd0, INCR, 0, 0, 0);
        chk("wrap_mem_unchanged", rcap[0], 32'hAA22CC44);
        axi_read(5'h0A, 32'h20, 8'd0, WRAP, 0, 0, 0);
        chk("wrap_rdata_zero", rcap[0], 32'h0);

        // wlast protocol errors still commit data
        wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002; ws[0] = 4'hF; ws[1] = 4'hF;
        wl[0] = 1'b1; wl[1] = 1'b1;
        axi_write(5'h0B, 32'h300, 8'd1, INCR, 0, 0);
        chk("early_wlast_bresp", bresp_cap, 2'b10);
        axi_read(5'h0C, 32'h300, 8'd1, INCR, 0, 0, 0);
        chk("early_wlast_beat0", rcap[0], 32'hCAFE0001);
        chk("early_wlast_beat1", rcap[1], 32'hCAFE0002);
        wd[0] = 32'h0BADF00D; wl[0] = 1'b0;
        axi_write(5'h0D, 32'h304, 8'd0, INCR, 0, 0);
        chk("missing_wlast_bresp", bresp_cap, 2'b10);

        // FIXED burst, aliasing, modulo wrap of the address
        wd[0] = 32'h0A0A0A0A; wd[1] = 32'h0B0B0B0B; wl[0] = 1'b0; wl[1] = 1'b1;
        axi_write(5'h0E, 32'h40, 8'd1, FIXED, 0, 0);
        axi_read(5'h0F, 32'h40, 8'd1, FIXED, 0, 0, 0);
        chk("fixed_beat0", rcap[0], 32'h0B0B0B0B);
        chk("fixed_beat1", rcap[1], 32'h0B0B0B0B);
        wd[0] = 32'h5A5AA5A5; wl[0] = 1'b1;
        axi_write(5'h10, 32'h1000_0080, 8'd0, INCR, 0, 0);
        chk("alias_bresp", bresp_cap, 2'b00);
        axi_read(5'h11, 32'h80, 8'd0, INCR, 0, 0, 0);
        chk("alias_rdata", rcap[0], 32'h5A5AA5A5);
        wd[0] = 32'h77777777; wd[1] = 32'h88888888; wl[0] = 1'b0; wl[1] = 1'b1;
        axi_write(5'h12, 32'hFFC, 8'd1, INCR, 0, 0);
        axi_read(5'h12, 32'h0, 8'd0, INCR, 0, 0, 0);
        chk("addr_wrap_rdata", rcap[0], 32'h88888888);

        // Reset in the middle of a read burst, then immediate read after release
        axi_read(5'h15, 32'h100, 8'd3, INCR, 0, 2, 0);
        axi_read(5'h16, 32'h100, 8'd3, INCR, 0, 0, 1);
        for (int i = 0; i < 4; i++) chk("post_reset_beat", rcap[i], 32'(i + 1));

        // Contending AW/AR: read, write, read
        wd[0] = 32'h01020304; ws[0] = 4'hF; wl[0] = 1'b1;
        grant_log.delete();
        fork
            begin
                axi_write(5'h05, 32'h200, 8'd0, INCR, 0, 0);
                axi_write(5'h07, 32'h204, 8'd0, INCR, 0, 0);
            end
            begin
                axi_read(5'h13, 32'h10, 8'd0, INCR, 0, 0, 0);
                chk("rr_rid_0x13", rid_cap, 5'h13);
                axi_read(5'h14, 32'h20, 8'd0, INCR, 0, 0, 0);
                chk("rr_rid_0x14", rid_cap, 5'h14);
            end
        join
        chk("rr_grant_count", grant_log.size(), 4);
        if (grant_log.size() >= 3) begin
            chk("rr_grant0_read", grant_log[0], 1);
            chk("rr_grant1_write", grant_log[1], 0);
            chk("rr_grant2_read", grant_log[2], 1);
        end
        chk("exp_r_drained", exp_r.size(), 0);
        chk("exp_b_drained", exp_b.size(), 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
